// File: rtl/alu_pkg.sv
// Shared encodings for ALU control decode and the execute stage:
// control codes, ALUOp values, funct7 patterns and FSM states.
package alu_pkg;

    localparam logic [3:0] CTL_AND     = 4'b0000;
    localparam logic [3:0] CTL_OR      = 4'b0001;
    localparam logic [3:0] CTL_ADD     = 4'b0010;
    localparam logic [3:0] CTL_XOR     = 4'b0011;
    localparam logic [3:0] CTL_SLL     = 4'b0100;
    localparam logic [3:0] CTL_SRL     = 4'b0101;
    localparam logic [3:0] CTL_SUB     = 4'b0110;
    localparam logic [3:0] CTL_SRA     = 4'b0111;
    localparam logic [3:0] CTL_SLT     = 4'b1000;
    localparam logic [3:0] CTL_SLTU    = 4'b1001;
    localparam logic [3:0] CTL_MUL     = 4'b1010;
    localparam logic [3:0] CTL_ILLEGAL = 4'b1111;

    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/alu_decode.sv
// Combinational ALU control decode: (alu_op, funct7, funct3) -> control code.
// Shared with the hazard unit, so it carries no state.
module alu_decode
    import alu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [6:0] funct7,
    input  logic [2:0] funct3,
    output logic [3:0] alu_ctl,
    output logic       is_mul,
    output logic       illegal
);

    always_comb begin
        alu_ctl = CTL_ILLEGAL;
        is_mul  = 1'b0;
        case (alu_op)
            ALUOP_MEM:    alu_ctl = CTL_ADD;
            ALUOP_BRANCH: alu_ctl = CTL_SUB;
            ALUOP_RTYPE: begin
                case (funct3)
                    3'b000: begin
                        if (funct7 == F7_BASE) begin
                            alu_ctl = CTL_ADD;
                        end else if (funct7 == F7_ALT) begin
                            alu_ctl = CTL_SUB;
                        end else if (funct7 == F7_MULDIV) begin
                            alu_ctl = CTL_MUL;
                            is_mul  = 1'b1;
                        end
                    end
                    3'b001: if (funct7 == F7_BASE) alu_ctl = CTL_SLL;
                    3'b010: if (funct7 == F7_BASE) alu_ctl = CTL_SLT;
                    3'b011: if (funct7 == F7_BASE) alu_ctl = CTL_SLTU;
                    3'b100: if (funct7 == F7_BASE) alu_ctl = CTL_XOR;
                    3'b101: begin
                        if (funct7 == F7_BASE) begin
                            alu_ctl = CTL_SRL;
                        end else if (funct7 == F7_ALT) begin
                            alu_ctl = CTL_SRA;
                        end
                    end
                    3'b110: if (funct7 == F7_BASE) alu_ctl = CTL_OR;
                    3'b111: if (funct7 == F7_BASE) alu_ctl = CTL_AND;
                    default: alu_ctl = CTL_ILLEGAL;
                endcase
            end
            default: alu_ctl = CTL_ILLEGAL;
        endcase
        // Any encoding not matched above keeps the illegal code.
        illegal = (alu_ctl == CTL_ILLEGAL);
    end

endmodule

// File: rtl/alu_ctrl_exec.sv
// ALU control plus execute stage: single-cycle ALU ops, iterative shift-add MUL,
// and a registered valid/ready result.
//
// state | meaning
// IDLE  | no result held, ready for a new op
// MUL   | shift-add multiply in progress, input stalled
// DONE  | result held on out_valid until out_ready
module alu_ctrl_exec
    import alu_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [6:0]      funct7,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] opa,
    input  logic [XLEN-1:0] opb,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic [3:0]      alu_ctl,
    output logic            illegal
);

    logic [3:0] dec_ctl;
    logic       dec_is_mul;
    logic       dec_illegal;

    alu_decode u_decode (
        .alu_op  (alu_op),
        .funct7  (funct7),
        .funct3  (funct3),
        .alu_ctl (dec_ctl),
        .is_mul  (dec_is_mul),
        .illegal (dec_illegal)
    );

    state_e          state_q, state_d;
    logic [XLEN-1:0] result_q;
    logic            zero_q;
    logic [3:0]      alu_ctl_q;
    logic            illegal_q;
    logic [XLEN-1:0] mcand_q;
    logic [XLEN-1:0] mplier_q;
    logic [XLEN-1:0] acc_q;
    logic [SHW-1:0]  cnt_q;

    logic            accept;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] mul_sum;

    assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign alu_ctl   = alu_ctl_q;
    assign illegal   = illegal_q;

    assign shamt   = opb[SHW-1:0];
    assign mul_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    // MUL and illegal codes fall to zero here; MUL is produced by the iterator.
    always_comb begin
        alu_res = '0;
        case (dec_ctl)
            CTL_AND:  alu_res = opa & opb;
            CTL_OR:   alu_res = opa | opb;
            CTL_ADD:  alu_res = opa + opb;
            CTL_XOR:  alu_res = opa ^ opb;
            CTL_SLL:  alu_res = opa << shamt;
            CTL_SRL:  alu_res = opa >> shamt;
            CTL_SUB:  alu_res = opa - opb;
            CTL_SRA:  alu_res = $signed(opa) >>> shamt;
            CTL_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(opa) < $signed(opb))};
            CTL_SLTU: alu_res = {{(XLEN-1){1'b0}}, (opa < opb)};
            default:  alu_res = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = dec_is_mul ? ST_MUL : ST_DONE;
            end
            ST_MUL: begin
                if (cnt_q == '0) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (accept) begin
                    state_d = dec_is_mul ? ST_MUL : ST_DONE;
                end else if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            result_q  <= '0;
            zero_q    <= 1'b0;
            alu_ctl_q <= CTL_AND;
            illegal_q <= 1'b0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                alu_ctl_q <= dec_ctl;
                illegal_q <= dec_illegal;
                if (dec_is_mul) begin
                    mcand_q  <= opa;
                    mplier_q <= opb;
                    acc_q    <= '0;
                    cnt_q    <= SHW'(XLEN - 1);
                end else begin
                    result_q <= alu_res;
                    zero_q   <= (alu_res == '0);
                end
            end else if (state_q == ST_MUL) begin
                acc_q    <= mul_sum;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                // Last iteration writes the final sum straight into the result.
                if (cnt_q == '0) begin
                    result_q <= mul_sum;
                    zero_q   <= (mul_sum == '0);
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_ctrl_exec.sv
// Directed self-checking bench for alu_ctrl_exec at XLEN=64.
module tb_alu_ctrl_exec;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  alu_op;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [63:0] opa, opb;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        zero;
    logic [3:0]  alu_ctl;
    logic        illegal;

    int errors = 0;
    int checks = 0;

    alu_ctrl_exec #(.XLEN(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .funct7    (funct7),
        .funct3    (funct3),
        .opa       (opa),
        .opb       (opb),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .alu_ctl   (alu_ctl),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                         input logic [63:0] a, input logic [63:0] b);
        in_valid = 1'b1;
        alu_op   = op;
        funct7   = f7;
        funct3   = f3;
        opa      = a;
        opb      = b;
    endtask

    // One op through an idle stage with out_ready high; outputs sampled after the accept edge.
    task automatic issue_check(input string name, input logic [1:0] op, input logic [6:0] f7,
                               input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                               input logic [63:0] exp_res, input logic [3:0] exp_ctl,
                               input logic exp_zero, input logic exp_ill);
        drive(op, f7, f3, a, b);
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== exp_res || alu_ctl !== exp_ctl ||
            zero !== exp_zero || illegal !== exp_ill) begin
            errors++;
            $display("FAIL %s got v=%b res=%h ctl=%b z=%b ill=%b exp v=1 res=%h ctl=%b z=%b ill=%b",
                     name, out_valid, result, alu_ctl, zero, illegal,
                     exp_res, exp_ctl, exp_zero, exp_ill);
        end
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 64'h0 ||
            zero !== 1'b0 || alu_ctl !== 4'b0000 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset got v=%b rdy=%b res=%h z=%b ctl=%b ill=%b exp v=0 rdy=1 res=0 z=0 ctl=0000 ill=0",
                     out_valid, in_ready, result, zero, alu_ctl, illegal);
        end
    endtask

    task automatic test_single_ops();
        out_ready = 1'b1;
        issue_check("add_mem", 2'b00, 7'h55, 3'b111, 64'h10, 64'h8, 64'h18, 4'b0010, 1'b0, 1'b0);
        issue_check("sub_branch", 2'b01, 7'h00, 3'b000, 64'h5, 64'h5, 64'h0, 4'b0110, 1'b1, 1'b0);
        issue_check("sra", 2'b10, 7'b0100000, 3'b101, 64'h8000_0000_0000_0000, 64'h43,
                    64'hF000_0000_0000_0000, 4'b0111, 1'b0, 1'b0);
        issue_check("srl", 2'b10, 7'b0000000, 3'b101, 64'h8000_0000_0000_0000, 64'h44,
                    64'h0800_0000_0000_0000, 4'b0101, 1'b0, 1'b0);
        issue_check("sll", 2'b10, 7'b0000000, 3'b001, 64'h1, 64'hFFC0_0000_0000_003F,
                    64'h8000_0000_0000_0000, 4'b0100, 1'b0, 1'b0);
        issue_check("slt", 2'b10, 7'b0000000, 3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1,
                    64'h1, 4'b1000, 1'b0, 1'b0);
        issue_check("sltu", 2'b10, 7'b0000000, 3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1,
                    64'h0, 4'b1001, 1'b1, 1'b0);
        issue_check("xor", 2'b10, 7'b0000000, 3'b100, 64'hFF00, 64'h0FF0, 64'hF0F0, 4'b0011, 1'b0, 1'b0);
        issue_check("sub_rtype", 2'b10, 7'b0100000, 3'b000, 64'h0, 64'h1,
                    64'hFFFF_FFFF_FFFF_FFFF, 4'b0110, 1'b0, 1'b0);
        issue_check("illegal_f7", 2'b10, 7'b0100000, 3'b001, 64'h7, 64'h9, 64'h0, 4'b1111, 1'b1, 1'b1);
        issue_check("illegal_op11", 2'b11, 7'b0000000, 3'b000, 64'h7, 64'h9, 64'h0, 4'b1111, 1'b1, 1'b1);
    endtask

    task automatic run_mul(input string name, input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] exp_res);
        int bad_cycle;
        bad_cycle = -1;
        out_ready = 1'b1;
        drive(2'b10, 7'b0000001, 3'b000, a, b);
        step();
        // Disturb the inputs during the multiply; they must not be sampled.
        drive(2'b00, 7'h00, 3'b000, ~a, 64'h1234);
        for (int i = 1; i <= 64; i++) begin
            if ((in_ready !== 1'b0 || out_valid !== 1'b0) && bad_cycle < 0) bad_cycle = i;
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (bad_cycle >= 0) begin
            errors++;
            $display("FAIL %s_stall got in_ready/out_valid high at cycle N+%0d exp both 0", name, bad_cycle);
        end
        checks++;
        if (out_valid !== 1'b1 || result !== exp_res || alu_ctl !== 4'b1010 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL %s got v=%b res=%h ctl=%b ill=%b exp v=1 res=%h ctl=1010 ill=0",
                     name, out_valid, result, alu_ctl, illegal, exp_res);
        end
        step();
    endtask

    task automatic test_mul();
        run_mul("mul_neg1x3", 64'hFFFF_FFFF_FFFF_FFFF, 64'h3, 64'hFFFF_FFFF_FFFF_FFFD);
        run_mul("mul_neg2xneg3", 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 64'h6);
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_r [3];
        logic [3:0]  exp_c [3];
        out_ready = 1'b1;
        exp_r[0] = 64'h7;  exp_c[0] = 4'b0010;
        exp_r[1] = 64'h30; exp_c[1] = 4'b0000;
        exp_r[2] = 64'hFF; exp_c[2] = 4'b0001;
        drive(2'b10, 7'h00, 3'b000, 64'h3, 64'h4);
        step();
        for (int i = 0; i < 3; i++) begin
            if (i == 0) drive(2'b10, 7'h00, 3'b111, 64'hF0, 64'h3C);
            else if (i == 1) drive(2'b10, 7'h00, 3'b110, 64'hF0, 64'h0F);
            else in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || result !== exp_r[i] || alu_ctl !== exp_c[i]) begin
                errors++;
                $display("FAIL b2b_%0d got v=%b rdy=%b res=%h ctl=%b exp v=1 rdy=1 res=%h ctl=%b",
                         i, out_valid, in_ready, result, alu_ctl, exp_r[i], exp_c[i]);
            end
            step();
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain got out_valid=%b exp 0", out_valid);
        end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        drive(2'b10, 7'h00, 3'b000, 64'h1, 64'h2);
        step();
        drive(2'b10, 7'h00, 3'b111, 64'hF0, 64'h3C);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 64'h3 || alu_ctl !== 4'b0010) begin
                errors++;
                $display("FAIL stall_hold_%0d got v=%b rdy=%b res=%h ctl=%b exp v=1 rdy=0 res=3 ctl=0010",
                         i, out_valid, in_ready, result, alu_ctl);
            end
            if (i < 2) step();
        end
        out_ready = 1'b1;
        step();
        drive(2'b10, 7'h00, 3'b110, 64'hF0, 64'h0F);
        checks++;
        if (out_valid !== 1'b1 || result !== 64'h30 || alu_ctl !== 4'b0000) begin
            errors++;
            $display("FAIL stall_second got v=%b res=%h ctl=%b exp v=1 res=30 ctl=0000",
                     out_valid, result, alu_ctl);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== 64'hFF || alu_ctl !== 4'b0001) begin
            errors++;
            $display("FAIL stall_third got v=%b res=%h ctl=%b exp v=1 res=ff ctl=0001",
                     out_valid, result, alu_ctl);
        end
        step();
    endtask

    task automatic test_reset_mid_mul();
        out_ready = 1'b1;
        drive(2'b10, 7'b0000001, 3'b000, 64'h5, 64'h7);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 64'h0 ||
            zero !== 1'b0 || alu_ctl !== 4'b0000 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_mul got v=%b rdy=%b res=%h z=%b ctl=%b ill=%b exp v=0 rdy=1 res=0 z=0 ctl=0000 ill=0",
                     out_valid, in_ready, result, zero, alu_ctl, illegal);
        end
        issue_check("add_after_rst", 2'b00, 7'h00, 3'b000, 64'h2, 64'h2, 64'h4, 4'b0010, 1'b0, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_op    = 2'b00;
        funct7    = 7'h00;
        funct3    = 3'b000;
        opa       = '0;
        opb       = '0;
        test_reset();
        test_single_ops();
        test_mul();
        test_back_to_back();
        test_stall();
        test_reset_mid_mul();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
